// File: rtl/spi_master_sched.sv
// spi_master_sched
// Round-robin arbitrated SPI master. Several requesters share one serial bus;
// each grant runs one 8-bit LSB-first full-duplex transfer to the selected
// slave. The received byte is returned with a one-cycle done pulse.
//
// Ports
//   SCLK      system/serial clock, rising edge active
//   reset     asynchronous, active-high
//   req       per-requester level request, held until its done
//   tx_data   8-bit word per requester, requester k at [8k+7:8k]
//   slave_sel target slave index per requester, requester k at [SEL_W*k +: SEL_W]
//   grant     one-hot owner of the current transaction (held through DONE)
//   done      one-cycle pulse on the owner's bit at completion
//   err       set with done when the target index has no chip select
//   rx_data   byte received in the last completed transaction
//   CS        active-high one-hot chip selects
//   MOSI/MISO serial data out/in
module spi_master_sched #(
   parameter int NUM_REQ    = 2,
   parameter int NUM_SLAVES = 2,
   parameter int SEL_W      = 1
) (
   input  logic                     SCLK,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [8*NUM_REQ-1:0]     tx_data,
   input  logic [SEL_W*NUM_REQ-1:0] slave_sel,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     err,
   output logic [7:0]               rx_data,
   output logic [NUM_SLAVES-1:0]    CS,
   output logic                     MOSI,
   input  logic                     MISO
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state;
   logic [IW-1:0]          ptr;      // first index to consider next arbitration
   logic [IW-1:0]          owner;
   logic [6:0]             tx_sh;    // remaining tx bits 7..1, next bit at [0]
   logic [6:0]             rx_sh;    // received bits shift in at the top
   logic [2:0]             bitcnt;

   // arbitration result
   logic                   found;
   int                     cand;
   logic [IW-1:0]          win;
   logic [7:0]             win_tx;
   logic [SEL_W-1:0]       win_sel;
   logic                   sel_bad;
   logic [NUM_SLAVES-1:0]  cs_dec;

   // Scan requesters starting at ptr, wrapping; the first active one wins.
   always_comb begin
      found   = 1'b0;
      cand    = 0;
      win     = '0;
      win_tx  = '0;
      win_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(ptr) + i) % NUM_REQ;
         if (!found && req[cand]) begin
            found   = 1'b1;
            win     = IW'(cand);
            win_tx  = tx_data[8*cand +: 8];
            win_sel = slave_sel[SEL_W*cand +: SEL_W];
         end
      end
   end

   // Compare in 32 bits so NUM_SLAVES == 2**SEL_W does not wrap to zero.
   always_comb begin
      sel_bad = int'(win_sel) >= NUM_SLAVES;
      for (int s = 0; s < NUM_SLAVES; s++)
         cs_dec[s] = (int'(win_sel) == s);
   end

   always_ff @(posedge SCLK or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         owner   <= '0;
         tx_sh   <= '0;
         rx_sh   <= '0;
         bitcnt  <= '0;
         grant   <= '0;
         done    <= '0;
         err     <= 1'b0;
         rx_data <= 8'h00;
         CS      <= '0;
         MOSI    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               grant <= '0;
               done  <= '0;
               CS    <= '0;
               if (found) begin
                  owner      <= win;
                  tx_sh      <= win_tx[7:1];
                  bitcnt     <= '0;
                  grant[win] <= 1'b1;
                  if (sel_bad) begin
                     // no slave to talk to: complete immediately with err
                     done[win] <= 1'b1;
                     err       <= 1'b1;
                     rx_data   <= 8'h00;
                     state     <= DONE;
                  end else begin
                     CS    <= cs_dec;
                     MOSI  <= win_tx[0];
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (bitcnt == 3'd7) begin
                  rx_data     <= {MISO, rx_sh};
                  err         <= 1'b0;
                  done[owner] <= 1'b1;
                  CS          <= '0;
                  state       <= DONE;
               end else begin
                  rx_sh  <= {MISO, rx_sh[6:1]};
                  MOSI   <= tx_sh[0];
                  tx_sh  <= {1'b0, tx_sh[6:1]};
                  bitcnt <= bitcnt + 3'd1;
               end
            end
            DONE: begin
               done  <= '0;
               grant <= '0;
               ptr   <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_sched.sv
// Bench for spi_master_sched: two-slave instance driven by byte-wise slave
// models, plus a single-slave instance for the out-of-range select case.
module tb_spi_master_sched;

   localparam int NR = 2;
   localparam int NS = 2;
   localparam int SW = 1;

   logic SCLK = 1'b0;
   logic reset;
   always #5 SCLK = ~SCLK;

   // main instance
   logic [NR-1:0]    req;
   logic [8*NR-1:0]  tx_data;
   logic [SW*NR-1:0] slave_sel;
   logic [NR-1:0]    grant, done;
   logic             err;
   logic [7:0]       rx_data;
   logic [NS-1:0]    CS;
   logic             MOSI, MISO;

   // single-slave instance
   logic [NR-1:0]    req1;
   logic [8*NR-1:0]  tx1;
   logic [SW*NR-1:0] sel1;
   logic [NR-1:0]    grant1, done1;
   logic             err1;
   logic [7:0]       rx1;
   logic [0:0]       cs1;
   logic             mosi1, miso1;

   spi_master_sched #(.NUM_REQ(NR), .NUM_SLAVES(NS), .SEL_W(SW)) u_dut (
      .SCLK(SCLK), .reset(reset), .req(req), .tx_data(tx_data), .slave_sel(slave_sel),
      .grant(grant), .done(done), .err(err), .rx_data(rx_data), .CS(CS),
      .MOSI(MOSI), .MISO(MISO));

   spi_master_sched #(.NUM_REQ(NR), .NUM_SLAVES(1), .SEL_W(SW)) u_dut1 (
      .SCLK(SCLK), .reset(reset), .req(req1), .tx_data(tx1), .slave_sel(sel1),
      .grant(grant1), .done(done1), .err(err1), .rx_data(rx1), .CS(cs1),
      .MOSI(mosi1), .MISO(miso1));

   // slave models: slave s returns smem[s] LSB first and captures MOSI
   logic [7:0] smem [NS] = '{8'h09, 8'h25};
   logic [7:0] srx  [NS];
   logic [3:0] scnt [NS];

   always @(posedge SCLK or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NS; s++) begin
            scnt[s] <= '0;
            srx[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < NS; s++) begin
            if (CS[s]) begin
               srx[s][scnt[s][2:0]] <= MOSI;
               scnt[s]              <= scnt[s] + 4'd1;
            end else begin
               scnt[s] <= '0;
            end
         end
      end
   end

   always_comb begin
      MISO = 1'b0;
      for (int s = 0; s < NS; s++)
         MISO = MISO | (CS[s] & smem[s][scnt[s][2:0]]);
   end

   // scoreboard
   typedef struct {
      int         idx;
      logic [7:0] rx;
      logic [7:0] srx;
      logic       err;
      int         sl;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   function automatic exp_t mk(int i, logic [7:0] r, logic [7:0] s, logic e, int sl);
      exp_t x;
      x.idx = i; x.rx = r; x.srx = s; x.err = e; x.sl = sl;
      return x;
   endfunction

   task automatic tick;
      @(negedge SCLK);
   endtask

   task automatic set_req(input int k, input logic [7:0] d, input logic [SW-1:0] s);
      tx_data[8*k +: 8]    = d;
      slave_sel[SW*k +: SW] = s;
      req[k]               = 1'b1;
   endtask

   // wait for a done pulse on the main instance; counts cycles with CS active
   task automatic wait_done(input int budget, output bit ok, output int cs_cyc);
      ok = 1'b0;
      cs_cyc = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge SCLK);
         if (CS != '0) cs_cyc++;
         if (done != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_cs(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge SCLK);
         if (CS != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset;
      reset = 1'b1;
      req   = '0;
      req1  = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      reset = 1'b1; req = '0; req1 = '0; tx_data = '0; slave_sel = '0;
      tx1 = '0; sel1 = '0; miso1 = 1'b0;
      tick();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
      checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx got %h want 00", rx_data); end
      checks++; if (CS !== 2'b00) begin errors++; $display("FAIL reset_cs got %b want 00", CS); end
      checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", MOSI); end
      checks++; if (cs1 !== 1'b0 || grant1 !== 2'b00) begin errors++; $display("FAIL reset_dut1 got cs %b grant %b want 0/00", cs1, grant1); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single;
      exp_t e; bit ok; int cs; logic [NR-1:0] eg;
      sb.push_back(mk(0, 8'h09, 8'h2B, 1'b0, 0));
      set_req(0, 8'h2B, 1'b0);
      wait_done(30, ok, cs);
      checks++; if (!ok) begin errors++; $display("FAIL single_timeout got none want done"); end
      e = sb.pop_front();
      eg = NR'(1) << e.idx;
      checks++; if (done !== eg) begin errors++; $display("FAIL single_done got %b want %b", done, eg); end
      checks++; if (grant !== eg) begin errors++; $display("FAIL single_grant got %b want %b", grant, eg); end
      checks++; if (rx_data !== e.rx) begin errors++; $display("FAIL single_rx got %h want %h", rx_data, e.rx); end
      checks++; if (err !== e.err) begin errors++; $display("FAIL single_err got %b want %b", err, e.err); end
      checks++; if (srx[e.sl] !== e.srx) begin errors++; $display("FAIL single_slave_rx got %h want %h", srx[e.sl], e.srx); end
      checks++; if (cs !== 8) begin errors++; $display("FAIL single_cs_cycles got %0d want 8", cs); end
      req = '0;
      tick();
      checks++; if (done !== 2'b00) begin errors++; $display("FAIL single_pulse got %b want 00", done); end
   endtask

   task automatic test_two;
      exp_t e; bit ok; int cs; int low; logic [NR-1:0] eg;
      do_reset();
      sb.push_back(mk(0, 8'h09, 8'h11, 1'b0, 0));
      sb.push_back(mk(1, 8'h25, 8'h5A, 1'b0, 1));
      set_req(0, 8'h11, 1'b0);
      set_req(1, 8'h5A, 1'b1);
      for (int n = 0; n < 2; n++) begin
         wait_done(30, ok, cs);
         checks++; if (!ok) begin errors++; $display("FAIL two_timeout%0d got none want done", n); end
         e = sb.pop_front();
         eg = NR'(1) << e.idx;
         checks++; if (grant !== eg) begin errors++; $display("FAIL two_grant%0d got %b want %b", n, grant, eg); end
         checks++; if (rx_data !== e.rx) begin errors++; $display("FAIL two_rx%0d got %h want %h", n, rx_data, e.rx); end
         checks++; if (srx[e.sl] !== e.srx) begin errors++; $display("FAIL two_slave_rx%0d got %h want %h", n, srx[e.sl], e.srx); end
         req[e.idx] = 1'b0;
         if (n == 0) begin
            low = 1;
            for (int c = 0; c < 10; c++) begin
               tick();
               if (CS != '0) break;
               low++;
            end
            checks++; if (low < 2) begin errors++; $display("FAIL two_cs_gap got %0d want >=2", low); end
         end
      end
      tick();
   endtask

   task automatic test_fair;
      exp_t e; bit ok; int cs; logic [NR-1:0] eg;
      for (int n = 0; n < 4; n++) sb.push_back(mk(n % 2, (n % 2) ? 8'h25 : 8'h09, (n % 2) ? 8'h3C : 8'hA5, 1'b0, n % 2));
      set_req(0, 8'hA5, 1'b0);
      set_req(1, 8'h3C, 1'b1);
      for (int n = 0; n < 4; n++) begin
         wait_done(30, ok, cs);
         checks++; if (!ok) begin errors++; $display("FAIL fair_timeout%0d got none want done", n); end
         e = sb.pop_front();
         eg = NR'(1) << e.idx;
         checks++; if (grant !== eg) begin errors++; $display("FAIL fair_grant%0d got %b want %b", n, grant, eg); end
         checks++; if (rx_data !== e.rx) begin errors++; $display("FAIL fair_rx%0d got %h want %h", n, rx_data, e.rx); end
         checks++; if (srx[e.sl] !== e.srx) begin errors++; $display("FAIL fair_slave_rx%0d got %h want %h", n, srx[e.sl], e.srx); end
      end
      req = '0;
      tick();
   endtask

   task automatic test_drop;
      exp_t e; bit ok; int cs; logic [NR-1:0] eg;
      sb.push_back(mk(0, 8'h09, 8'hC3, 1'b0, 0));
      set_req(0, 8'hC3, 1'b0);
      wait_cs(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_start got none want cs"); end
      repeat (2) tick();
      req[0] = 1'b0;
      wait_done(30, ok, cs);
      checks++; if (!ok) begin errors++; $display("FAIL drop_timeout got none want done"); end
      e = sb.pop_front();
      eg = NR'(1) << e.idx;
      checks++; if (done !== eg) begin errors++; $display("FAIL drop_done got %b want %b", done, eg); end
      checks++; if (rx_data !== e.rx) begin errors++; $display("FAIL drop_rx got %h want %h", rx_data, e.rx); end
      checks++; if (srx[e.sl] !== e.srx) begin errors++; $display("FAIL drop_slave_rx got %h want %h", srx[e.sl], e.srx); end
      tick();
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL drop_grant_clear got %b want 00", grant); end
   endtask

   task automatic test_invalid;
      exp_t e; bit ok; logic [NR-1:0] eg;
      // valid transfer first so rx1 holds a non-zero byte
      miso1 = 1'b1;
      tx1[7:0] = 8'h5C; sel1[0] = 1'b0; req1[0] = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (done1 != '0) begin ok = 1'b1; break; end
      end
      checks++; if (!ok || rx1 !== 8'hFF) begin errors++; $display("FAIL inv_pre_rx got %h want ff", rx1); end
      req1 = '0;
      tick();
      sb.push_back(mk(0, 8'h00, 8'h00, 1'b1, 0));
      sel1[0] = 1'b1; req1[0] = 1'b1;
      tick();
      e = sb.pop_front();
      eg = NR'(1) << e.idx;
      checks++; if (done1 !== eg) begin errors++; $display("FAIL inv_done got %b want %b", done1, eg); end
      checks++; if (err1 !== e.err) begin errors++; $display("FAIL inv_err got %b want %b", err1, e.err); end
      checks++; if (rx1 !== e.rx) begin errors++; $display("FAIL inv_rx got %h want %h", rx1, e.rx); end
      checks++; if (cs1 !== 1'b0) begin errors++; $display("FAIL inv_cs got %b want 0", cs1); end
      checks++; if (grant1 !== eg) begin errors++; $display("FAIL inv_grant got %b want %b", grant1, eg); end
      req1 = '0;
      tick();
      checks++; if (done1 !== 2'b00) begin errors++; $display("FAIL inv_pulse got %b want 00", done1); end
      checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL inv_err_hold got %b want 1", err1); end
      tick();
   endtask

   task automatic test_reset_mid;
      exp_t e; bit ok; int cs; logic [NR-1:0] eg;
      // pointer sits at 1 here, so a non-reset pointer would favour requester 1
      set_req(1, 8'h77, 1'b1);
      wait_cs(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rmid_start got none want cs"); end
      repeat (4) tick();
      reset = 1'b1;
      #1;
      checks++; if (CS !== 2'b00) begin errors++; $display("FAIL rmid_cs got %b want 00", CS); end
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_grant got %b want 00", grant); end
      checks++; if (done !== 2'b00) begin errors++; $display("FAIL rmid_done got %b want 00", done); end
      req = '0;
      tick();
      reset = 1'b0;
      tick();
      sb.push_back(mk(0, 8'h09, 8'h44, 1'b0, 0));
      sb.push_back(mk(1, 8'h25, 8'h66, 1'b0, 1));
      set_req(0, 8'h44, 1'b0);
      set_req(1, 8'h66, 1'b1);
      for (int n = 0; n < 2; n++) begin
         wait_done(30, ok, cs);
         checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout%0d got none want done", n); end
         e = sb.pop_front();
         eg = NR'(1) << e.idx;
         checks++; if (grant !== eg) begin errors++; $display("FAIL rmid_grant%0d got %b want %b", n, grant, eg); end
         checks++; if (rx_data !== e.rx) begin errors++; $display("FAIL rmid_rx%0d got %h want %h", n, rx_data, e.rx); end
         checks++; if (srx[e.sl] !== e.srx) begin errors++; $display("FAIL rmid_slave_rx%0d got %h want %h", n, srx[e.sl], e.srx); end
         req[e.idx] = 1'b0;
      end
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_two();
      test_fair();
      test_drop();
      test_invalid();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master_sched.md
# spi_master_sched

Arbitrated SPI master controller that shares one serial bus (MOSI/MISO and one-hot chip selects) among several on-chip requesters. Each requester posts an 8-bit word and a target slave index. The block grants requesters round-robin and runs one 8-bit LSB-first full-duplex transfer per grant against the `Slave` instances. It returns the received byte with a done pulse. It sits between the system-side clients and the slave array, and is the only driver of `CS` and `MOSI`.

## Interface
- `NUM_REQ`, 2, number of requesters (≥1)
- `NUM_SLAVES`, 2, number of chip selects (≥1)
- `SEL_W`, 1, width of one slave-select field (2^SEL_W ≥ NUM_SLAVES)

- `SCLK`  in  1  serial/system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high
- `req`  in  NUM_REQ  per-requester level request, held until its done
- `tx_data`  in  8·NUM_REQ  word for requester k at bits [8k+7:8k]
- `slave_sel`  in  SEL_W·NUM_REQ  target slave index for requester k
- `grant`  out  NUM_REQ  one-hot owner of the current transaction, else 0
- `done`  out  NUM_REQ  one-cycle pulse on the owner's bit at completion
- `err`  out  1  high with `done` when `slave_sel` ≥ NUM_SLAVES
- `rx_data`  out  8  byte received in the last completed transaction
- `CS`  out  NUM_SLAVES  active-high one-hot chip select, 0 when idle
- `MOSI`  out  1  serial data to slaves
- `MISO`  in  1  shared serial data from slaves

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `CS`=0, `grant`=0.
  - If any `req` bit is high, pick a winner round-robin, starting at the index after the last winner.
  - Latch the winner's `tx_data` and `slave_sel`, and set `grant`.
  - Valid select: set the `CS` bit, drive `MOSI`=tx[0], clear `bitcnt`, go to SHIFT.
  - Invalid select: go to DONE with `err` set; `rx_data` ← 8'h00; no `CS` asserted.
- SHIFT, on each edge:
  - `rx[bitcnt]` ← `MISO`.
  - If `bitcnt`==7, go to DONE and drop `CS`.
  - Otherwise `bitcnt`++ and `MOSI` ← tx[bitcnt+1].
- DONE: `done[winner]`=1 for exactly one cycle; `rx_data` updated on entry; then go to IDLE and update the RR pointer.
- Bit order: LSB first in both directions.
- Requester drops `req` mid-transfer: the transfer completes and `done` still pulses. `grant` is held through DONE.
- `tx_data`/`slave_sel` changes after the grant edge are ignored.
- `rx_data` and `err` hold their value until the next DONE.
- Reset at any time forces IDLE and releases `CS` immediately (asynchronous). The RR pointer resets so requester 0 has highest priority.

## Timing
- Reset values: `grant`=0, `done`=0, `err`=0, `rx_data`=8'h00, `CS`=0, `MOSI`=0.
- Cycle timeline, with edge e0 = IDLE sampling `req`:
  - e0: `CS` and `MOSI`=tx[0] valid.
  - e1..e8: MISO bits 0..7 sampled.
  - e8: `CS` falls.
  - e8–e9: `done`/`rx_data` valid.
  - e9: back to IDLE.
- Earliest next grant is e10. `CS` is low for at least 2 cycles between back-to-back transactions.
- Invalid-select transaction: `done` and `err` high during e0–e1.
- Simultaneous requests with pointer at k: the lowest index ≥k wins, wrapping to 0.

## Test plan
- Requester 0 sends 0x2B to slave 0, which holds 0x09 → `CS`=01 for exactly 8 cycles, `done`=01 pulse, `rx_data`=0x09, slave 0 receives 0x2B.
- Both `req` high; req0 targets slave 0, req1 targets slave 1 (slave 1 holds 0x25) → grant order 0 then 1, `rx_data` 0x09 then 0x25, `CS` low for ≥2 cycles between.
- Both requests held continuously for 4 transactions → grants alternate 0,1,0,1; neither is starved.
- `slave_sel`=1 on requester 0 with NUM_SLAVES=1 → no `CS`, `done`=01 and `err`=1 in the cycle after the grant edge, `rx_data`=0x00.
- Assert `reset` at bit 4 of a transfer → `CS`, `grant`, `done` go to 0 asynchronously; after release, a new request completes correctly with requester 0 at top priority.
- Requester drops `req` at bit 2 → transfer still finishes 8 bits and `done` pulses for that requester.
